// File: rtl/stream_pkg.sv
// Shared definitions for the stream-path blocks: counter widths, the flush
// state encoding and a level-width helper.
package stream_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Bits needed to hold a fill level in 0..cap inclusive.
  function automatic int level_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/stream_gearbox.sv
// Bit-stream width converter: IN_WIDTH-bit words in, OUT_WIDTH-bit words out,
// through a CAP-bit shift buffer with zero-padded flush and optional drop-on-full.
module stream_gearbox
  import stream_pkg::*;
#(
  parameter int IN_WIDTH     = 2,
  parameter int OUT_WIDTH    = 1,
  parameter int CAP          = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  flushing,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int LVL_W = level_width(CAP);
  localparam logic [LVL_W-1:0] IN_W_L   = LVL_W'(IN_WIDTH);
  localparam logic [LVL_W-1:0] OUT_W_L  = LVL_W'(OUT_WIDTH);
  localparam logic [LVL_W-1:0] ROOM_MAX = LVL_W'(CAP - IN_WIDTH);

  if (CAP < IN_WIDTH + OUT_WIDTH) begin : g_bad_cap
    $error("stream_gearbox: CAP must be at least IN_WIDTH + OUT_WIDTH");
  end

  // Earliest bit lives at index 0; bits at and above level_q are always zero,
  // which makes the zero padding of a partial flush word free.
  logic [CAP-1:0]        bits_q, bits_d;
  logic [LVL_W-1:0]      level_q, level_d;
  flush_state_e          state_q, state_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic                  flush_pending, room, accept_ok, store, drop, out_fire;
  logic [LVL_W-1:0]      rem, keep;
  logic [IN_WIDTH-1:0]   in_word;
  logic [CAP-1:0]        in_ext, shifted;

  genvar gi;
  for (gi = 0; gi < IN_WIDTH; gi++) begin : g_in_order
    if (MSB_FIRST) begin : g_msb
      assign in_word[gi] = in_data[IN_WIDTH-1-gi];
    end else begin : g_lsb
      assign in_word[gi] = in_data[gi];
    end
  end

  for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_out_order
    if (MSB_FIRST) begin : g_msb
      assign out_data[gi] = bits_q[OUT_WIDTH-1-gi];
    end else begin : g_lsb
      assign out_data[gi] = bits_q[gi];
    end
  end

  assign in_ext        = {{(CAP-IN_WIDTH){1'b0}}, in_word};
  assign flush_pending = (state_q == FLUSH);
  assign room          = (level_q <= ROOM_MAX);
  assign accept_ok     = room & ~flush_pending;
  assign in_ready      = DROP_ON_FULL ? rst_n : (accept_ok & rst_n);
  assign store         = in_valid & rst_n & accept_ok;
  assign drop          = DROP_ON_FULL & in_valid & rst_n & ~accept_ok;
  assign out_valid     = (level_q >= OUT_W_L) | (flush_pending & (level_q != '0));
  assign out_fire      = out_valid & out_ready;
  assign flushing      = flush_pending;
  assign drop_count    = drop_count_q;

  always_comb begin
    rem = '0;
    if (out_fire) begin
      rem = (level_q < OUT_W_L) ? level_q : OUT_W_L;
    end
    keep    = level_q - rem;
    shifted = bits_q >> rem;
    bits_d  = shifted;
    level_d = keep;
    // Removal happens first so the new word lands right behind what is left.
    if (store) begin
      bits_d  = shifted | (in_ext << keep);
      level_d = keep + IN_W_L;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
      FLUSH:   if (level_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits_q       <= '0;
      level_q      <= '0;
      state_q      <= IDLE;
      drop_count_q <= '0;
    end else begin
      bits_q       <= bits_d;
      level_q      <= level_d;
      state_q      <= state_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_stream_gearbox.sv
// Directed bench for stream_gearbox: four instances covering 2->1, 1->3,
// 3->2 and drop-on-full LSB-first configurations.
module tb_stream_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2->1, MSB first, normal mode
  logic a_rst_n, a_iv, a_ir, a_ov, a_od, a_ordy, a_fl, a_flg;
  logic [1:0]  a_id;
  logic [15:0] a_dc;
  // Instance B: 1->3, MSB first
  logic b_rst_n, b_iv, b_id, b_ir, b_ov, b_ordy, b_fl, b_flg;
  logic [2:0]  b_od;
  logic [15:0] b_dc;
  // Instance C: 3->2, MSB first
  logic c_rst_n, c_iv, c_ir, c_ov, c_ordy, c_fl, c_flg;
  logic [2:0]  c_id;
  logic [1:0]  c_od;
  logic [15:0] c_dc;
  // Instance D: 2->1, LSB first, drop on full
  logic d_rst_n, d_iv, d_ir, d_ov, d_od, d_ordy, d_fl, d_flg;
  logic [1:0]  d_id;
  logic [15:0] d_dc;

  stream_gearbox #(.IN_WIDTH(2), .OUT_WIDTH(1), .CAP(8), .MSB_FIRST(1'b1), .DROP_ON_FULL(1'b0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(a_ordy), .flush(a_fl),
    .flushing(a_flg), .drop_count(a_dc));

  stream_gearbox #(.IN_WIDTH(1), .OUT_WIDTH(3), .CAP(8), .MSB_FIRST(1'b1), .DROP_ON_FULL(1'b0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy), .flush(b_fl),
    .flushing(b_flg), .drop_count(b_dc));

  stream_gearbox #(.IN_WIDTH(3), .OUT_WIDTH(2), .CAP(8), .MSB_FIRST(1'b1), .DROP_ON_FULL(1'b0)) u_c (
    .clk(clk), .rst_n(c_rst_n), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_ready(c_ordy), .flush(c_fl),
    .flushing(c_flg), .drop_count(c_dc));

  stream_gearbox #(.IN_WIDTH(2), .OUT_WIDTH(1), .CAP(8), .MSB_FIRST(1'b0), .DROP_ON_FULL(1'b1)) u_d (
    .clk(clk), .rst_n(d_rst_n), .in_valid(d_iv), .in_data(d_id), .in_ready(d_ir),
    .out_valid(d_ov), .out_data(d_od), .out_ready(d_ordy), .flush(d_fl),
    .flushing(d_flg), .drop_count(d_dc));

  typedef struct {
    logic       iv;
    logic [1:0] d;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic       od;
    logic       ir;
    logic       fg;
  } vec_t;

  vec_t a_tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] d_words[10];
  logic       d_bits[8];
  int         accepted;

  initial begin
    // iv, d, ordy, fl | ov, od, ir, fg  (outputs expected in the same cycle)
    a_tbl[0]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_tbl[1]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[2]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    a_tbl[3]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    a_tbl[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[5]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_tbl[6]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[8]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    a_tbl[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    a_tbl[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    a_tbl[11] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_tbl[12] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    a_tbl[13] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[14] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[15] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[16] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a_tbl[17] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a_tbl[18] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    a_tbl[19] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_tbl[20] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    d_words = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    d_bits  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    {a_rst_n, b_rst_n, c_rst_n, d_rst_n} = 4'b0000;
    {a_iv, a_id, a_ordy, a_fl} = '0;
    {b_iv, b_id, b_ordy, b_fl} = '0;
    {c_iv, c_id, c_ordy, c_fl} = '0;
    {d_iv, d_id, d_ordy, d_fl} = '0;
    repeat (2) cyc();

    // Reset state
    chk("reset_out_valid", a_ov, 1'b0);
    chk("reset_out_data", a_od, 1'b0);
    chk("reset_in_ready", a_ir, 1'b0);
    chk("reset_flushing", a_flg, 1'b0);
    chk("reset_drop_count", a_dc, 16'h0);
    chk("reset_b_out_data", b_od, 3'b000);
    {a_rst_n, b_rst_n, c_rst_n, d_rst_n} = 4'b1111;
    #1;

    // A: table-driven 2->1 stream, flush, fill/full and drain
    for (int i = 0; i < 21; i++) begin
      a_iv = a_tbl[i].iv; a_id = a_tbl[i].d; a_ordy = a_tbl[i].ordy; a_fl = a_tbl[i].fl;
      #1;
      $display("A vec %0d: in_valid=%0b in_data=%b out_ready=%0b flush=%0b -> out_valid=%0b out_data=%0b in_ready=%0b flushing=%0b",
               i, a_iv, a_id, a_ordy, a_fl, a_ov, a_od, a_ir, a_flg);
      chk($sformatf("A%0d_out_valid", i), a_ov, a_tbl[i].ov);
      chk($sformatf("A%0d_out_data", i), a_od, a_tbl[i].od);
      chk($sformatf("A%0d_in_ready", i), a_ir, a_tbl[i].ir);
      chk($sformatf("A%0d_flushing", i), a_flg, a_tbl[i].fg);
      cyc();
    end

    // A: reset with level 5 and a flush pending, then a fresh word
    a_fl = 1'b0; a_iv = 1'b0; a_ordy = 1'b0;
    #1;
    chk("A_pre_reset_flushing", a_flg, 1'b1);
    a_rst_n = 1'b0;
    #1;
    chk("A_in_ready_in_reset", a_ir, 1'b0);
    cyc();
    $display("A reset: out_valid=%0b flushing=%0b drop_count=%0d", a_ov, a_flg, a_dc);
    chk("A_post_reset_out_valid", a_ov, 1'b0);
    chk("A_post_reset_flushing", a_flg, 1'b0);
    chk("A_post_reset_drop_count", a_dc, 16'h0);
    a_rst_n = 1'b1; a_iv = 1'b1; a_id = 2'b01; a_ordy = 1'b1;
    #1;
    chk("A_after_reset_in_ready", a_ir, 1'b1);
    cyc();
    a_iv = 1'b0;
    #1;
    chk("A_new_bit0_valid", a_ov, 1'b1);
    chk("A_new_bit0", a_od, 1'b0);
    cyc();
    chk("A_new_bit1_valid", a_ov, 1'b1);
    chk("A_new_bit1", a_od, 1'b1);
    cyc();
    chk("A_new_empty", a_ov, 1'b0);

    // B: 1->3, bits 1,1,0,1 with flush alongside the last bit
    b_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_iv = 1'b1; b_id = (i == 2) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("B_fill%0d_out_valid", i), b_ov, 1'b0);
      cyc();
    end
    b_iv = 1'b1; b_id = 1'b1; b_fl = 1'b1;
    #1;
    $display("B word0: out_valid=%0b out_data=%b flushing=%0b", b_ov, b_od, b_flg);
    chk("B_word0_valid", b_ov, 1'b1);
    chk("B_word0_data", b_od, 3'b110);
    chk("B_word0_in_ready", b_ir, 1'b1);
    chk("B_word0_flushing", b_flg, 1'b0);
    cyc();
    b_iv = 1'b0; b_fl = 1'b0;
    #1;
    $display("B word1: out_valid=%0b out_data=%b flushing=%0b", b_ov, b_od, b_flg);
    chk("B_word1_valid", b_ov, 1'b1);
    chk("B_word1_data", b_od, 3'b100);
    chk("B_word1_flushing", b_flg, 1'b1);
    chk("B_word1_in_ready", b_ir, 1'b0);
    cyc();
    chk("B_done_flushing", b_flg, 1'b0);
    chk("B_done_valid", b_ov, 1'b0);
    // Flush on an empty buffer lasts one cycle
    b_fl = 1'b1;
    #1;
    cyc();
    b_fl = 1'b0;
    #1;
    chk("B_empty_flush_flushing", b_flg, 1'b1);
    chk("B_empty_flush_valid", b_ov, 1'b0);
    cyc();
    chk("B_empty_flush_done", b_flg, 1'b0);

    // C: 3->2 under backpressure, then release
    accepted = 0;
    c_ordy = 1'b0; c_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_id = (i == 0) ? 3'b101 : (i == 1) ? 3'b011 : 3'b110;
      #1;
      if (c_iv && c_ir) accepted++;
      $display("C stall %0d: in_ready=%0b out_valid=%0b out_data=%b", i, c_ir, c_ov, c_od);
      if (i > 0) chk($sformatf("C_stall%0d_data", i), c_od, 2'b10);
      cyc();
    end
    chk("C_accepted_words", accepted, 2);
    chk("C_full_in_ready", c_ir, 1'b0);
    c_ordy = 1'b1;
    #1;
    chk("C_release_in_ready", c_ir, 1'b0);
    chk("C_release_data", c_od, 2'b10);
    cyc();
    chk("C_w1_in_ready", c_ir, 1'b1);
    chk("C_w1_data", c_od, 2'b10);
    cyc();
    c_iv = 1'b0;
    #1;
    chk("C_w2_data", c_od, 2'b11);
    cyc();
    chk("C_w3_valid", c_ov, 1'b1);
    chk("C_w3_data", c_od, 2'b11);
    cyc();
    chk("C_residual_not_valid", c_ov, 1'b0);

    // D: drop-on-full, 10 words with no output drain, LSB first
    d_ordy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d_iv = 1'b1; d_id = d_words[i];
      #1;
      chk($sformatf("D_in%0d_in_ready", i), d_ir, 1'b1);
      cyc();
    end
    d_iv = 1'b0;
    #1;
    $display("D after 10 words: drop_count=%0d", d_dc);
    chk("D_drop_count_6", d_dc, 16'd6);
    d_ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      $display("D drain %0d: out_valid=%0b out_data=%0b", i, d_ov, d_od);
      chk($sformatf("D_bit%0d_valid", i), d_ov, 1'b1);
      chk($sformatf("D_bit%0d", i), d_od, d_bits[i]);
      cyc();
    end
    chk("D_drained", d_ov, 1'b0);

    // D: saturation of drop_count
    d_rst_n = 1'b0;
    cyc();
    chk("D_reset_drop_count", d_dc, 16'h0);
    d_rst_n = 1'b1; d_ordy = 1'b0; d_iv = 1'b1; d_id = 2'b10;
    repeat (4) cyc();
    chk("D_fill_no_drops", d_dc, 16'h0);
    repeat (65534) cyc();
    $display("D after 65534 drops: drop_count=%0h", d_dc);
    chk("D_drop_count_fffe", d_dc, 16'hFFFE);
    repeat (6) cyc();
    $display("D after 65540 drops: drop_count=%0h", d_dc);
    chk("D_drop_count_sat", d_dc, 16'hFFFF);
    d_iv = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
